peridot_pfc_bridge: RTL and testbench
=====================================

// Module: peridot_pfc_bridge
// PURPOSE
//  Avalon-MM slave to PFC command-bus initiator. Drives the 37-bit pfc_cmd bus
//  and samples the 32-bit pfc_resp bus fed back by the bank decoder and the
//  peridot_pfc banks in the top level. Converts CPU reads and writes into
//  single-cycle write strobes and timed response sampling.
//  Partial-byte writes become read-modify-write sequences; the pfc banks have
//  no byte enables.
// PARAMETERS
//  READ_WAIT  1  cycles cmd address is held before pfc_resp is sampled (1..15)
// PORTS
//  csi_clk           in   1   single clock; also the pfc bus clock
//  rsi_reset_n       in   1   asynchronous, active-low reset
//  avs_address       in   4   [3:2]=bank (->cmd[35:34]), [1:0]=reg (->cmd[33:32])
//  avs_read          in   1   read request
//  avs_write         in   1   write request
//  avs_writedata     in   32  write data
//  avs_byteenable    in   4   byte lanes of writedata
//  avs_readdata      out  32  read data; valid in the avs_waitrequest=0 cycle of a read
//  avs_waitrequest   out  1   0 for exactly one cycle, which completes the transfer
//  coe_pfc_clk       out  1   equals csi_clk
//  coe_pfc_reset     out  1   active-high pfc reset (synchronised, see below)
//  coe_pfc_cmd       out  37  {write strobe, bank[1:0], reg[1:0], data[31:0]}
//  coe_pfc_resp      in   32  read data from the addressed bank (combinational)
// BEHAVIOUR
//  Reset values
//   - Outputs: readdata=0, waitrequest=1, cmd=0, coe_pfc_reset=1.
//   - FSM state is IDLE.
//  coe_pfc_reset
//   - Asserts asynchronously with reset.
//   - Deasserts through a 2-flop synchroniser: low on the 2nd rising edge after
//     rsi_reset_n goes high.
//   - While it is high, the FSM stays in IDLE and ignores requests.
//  Master rule
//   - The master holds address, data and control stable while waitrequest=1.
//   - If read and write are both set, the write wins; the read is dropped.
//  FSM states: IDLE, RD, DONE, RMW, WR.
//  IDLE (waitrequest=1)
//   - On a write, latch the request; cmd[35:32] <= address.
//   - Write with byteenable=F: go to WR.
//   - Write with byteenable=0: go to DONE. No strobe is issued.
//   - Write with any other byteenable: go to RMW.
//   - On a read: cmd[35:32] <= address, then go to RD.
//  RD (READ_WAIT cycles, cmd[36]=0)
//   - At the end of the last cycle: readdata <= pfc_resp, then go to DONE.
//  DONE
//   - waitrequest=0 for one cycle, then return to IDLE.
//  RMW (READ_WAIT cycles, cmd[36]=0)
//   - At the end of the last cycle: cmd[31:0] <= per-byte merge.
//   - Merge: byte i comes from writedata if byteenable[i], else from pfc_resp.
//   - Then go to WR.
//  WR
//   - cmd[36]=1 for exactly one cycle and waitrequest=0 in the same cycle.
//   - Then return to IDLE.
//  Latency (IDLE cycle to waitrequest=0)
//   - Full write: 1 cycle.
//   - Partial write: READ_WAIT+1 cycles.
//   - Read: READ_WAIT+1 cycles.
//  cmd bus rules
//   - cmd[36] is never high outside WR.
//   - cmd[35:0] hold their last value in IDLE.
//   - cmd[31:0] changes only when entering WR.
//  Reset mid-transaction
//   - Immediate return to IDLE; cmd=0.
//   - No partial strobe; no waitrequest=0 pulse.
//   - The interrupted transfer is lost.
//  Back-to-back transfers
//   - Each returns through IDLE: at least 1 idle cycle between strobes.
// TESTING (READ_WAIT=1 unless noted)
//  - Reset release
//    - Stimulus: release reset.
//    - Required: coe_pfc_reset falls on the 2nd edge.
//    - Required: a write presented earlier gets no strobe until after that edge.
//  - Full write
//    - Stimulus: addr=4'h6, wdata=32'h00110000, be=F.
//    - Required: one cycle of cmd=37'h1_6_00110000, waitrequest=0 in that same
//      cycle, then cmd[36]=0.
//  - Read
//    - Stimulus: addr=4'hB, resp=32'hCAFE0001.
//    - Required: cmd[35:32]=4'hB, then waitrequest=0 two cycles after the
//      request with readdata=32'hCAFE0001.
//    - Required: no strobe.
//  - Partial write
//    - Stimulus: be=4'b0010, wdata=32'h0000AB00, resp=32'h11223344.
//    - Required: a single strobe with cmd[31:0]=32'h1122AB44.
//    - Repeat with READ_WAIT=3; required: 4-cycle latency.
//  - Edge cases
//    - be=0: waitrequest=0 pulse with no strobe.
//    - read+write together: write only.
//    - Reset asserted in RD: no waitrequest=0 pulse and cmd=0.
//  - Back-to-back full writes: strobes separated by at least 1 low cycle; the
//    second strobe carries the second address and data.

Source files
------------

// File: rtl/peridot_pfc_bridge.sv
// ---------------------------------------------------------------------------
// peridot_pfc_bridge
//
// Purpose:
//   Avalon-MM slave that turns CPU reads and writes into transfers on the PFC
//   command bus. Writes become a single-cycle strobe on cmd[36]. Reads hold
//   the bank/register address on the bus for READ_WAIT cycles, then capture
//   the combinational response. The PFC banks have no byte enables, so a
//   partial-byte write first reads the current word, merges in the enabled
//   bytes, and then writes the merged word back.
//
// Parameters:
//   READ_WAIT        cycles the address is held before pfc_resp is sampled (1..15)
//
// Ports:
//   csi_clk          in   1   single clock, also forwarded as the PFC bus clock
//   rsi_reset_n      in   1   asynchronous active-low reset
//   avs_address      in   4   [3:2] bank, [1:0] register
//   avs_read         in   1   read request
//   avs_write        in   1   write request (wins over a simultaneous read)
//   avs_writedata    in   32  write data
//   avs_byteenable   in   4   byte lanes of writedata
//   avs_readdata     out  32  read data, valid in the completing cycle
//   avs_waitrequest  out  1   low for exactly one cycle to complete a transfer
//   coe_pfc_clk      out  1   copy of csi_clk
//   coe_pfc_reset    out  1   active-high PFC reset, released synchronously
//   coe_pfc_cmd      out  37  {strobe, bank[1:0], reg[1:0], data[31:0]}
//   coe_pfc_resp     in   32  read data from the addressed bank
// ---------------------------------------------------------------------------
module peridot_pfc_bridge #(
    parameter int READ_WAIT = 1
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        coe_pfc_clk,
    output logic        coe_pfc_reset,
    output logic [36:0] coe_pfc_cmd,
    input  logic [31:0] coe_pfc_resp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_DONE,
        S_RMW,
        S_WR
    } state_t;

    // Counter reload value: the wait counter runs READ_WAIT-1 down to 0.
    localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [3:0]  cnt_q, cnt_d;

    // Byte i is taken from the new write data when its enable is set,
    // otherwise from the word currently held by the bank.
    function automatic logic [31:0] merge_bytes(input logic [31:0] wdata,
                                                input logic [3:0]  be,
                                                input logic [31:0] old);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

    // Reset synchroniser: asserts with rsi_reset_n, releases on the 2nd
    // rising edge after rsi_reset_n goes high.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                // Requests are ignored until the PFC side is out of reset.
                if (!sync_q[1]) begin
                    if (avs_write) begin
                        addr_d  = avs_address;
                        wdata_d = avs_writedata;
                        be_d    = avs_byteenable;
                        if (avs_byteenable == 4'hF) begin
                            // Full word: data goes straight onto the bus.
                            data_d  = avs_writedata;
                            state_d = S_WR;
                        end else if (avs_byteenable == 4'h0) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d   = WAIT_LAST;
                            state_d = S_RMW;
                        end
                    end else if (avs_read) begin
                        addr_d  = avs_address;
                        cnt_d   = WAIT_LAST;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = coe_pfc_resp;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_RMW: begin
                if (cnt_q == 4'd0) begin
                    data_d  = merge_bytes(wdata_q, be_q, coe_pfc_resp);
                    state_d = S_WR;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The strobe and the acknowledge both decode directly from the state
    // register, so they are glitch-free and coincide in the WR cycle.
    assign avs_waitrequest = !((state_q == S_DONE) || (state_q == S_WR));
    assign avs_readdata    = rdata_q;
    assign coe_pfc_cmd     = {(state_q == S_WR), addr_q, data_q};
    assign coe_pfc_clk     = csi_clk;
    assign coe_pfc_reset   = sync_q[1];

endmodule

// File: tb/tb_peridot_pfc_bridge.sv
module tb_peridot_pfc_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        bank_clr;
    logic [3:0]  addr  [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [31:0] rdata [2];
    logic        waitreq [2];
    logic        pclk  [2];
    logic        preset [2];
    logic [36:0] cmd   [2];
    logic [31:0] resp  [2];

    // Instance 0 uses READ_WAIT=1, instance 1 uses READ_WAIT=3. Each has its
    // own behavioural bank array answering reads and absorbing strobes.
    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            logic [31:0] bank [16];

            peridot_pfc_bridge #(.READ_WAIT(g == 0 ? 1 : 3)) u_dut (
                .csi_clk        (clk),
                .rsi_reset_n    (rst_n),
                .avs_address    (addr[g]),
                .avs_read       (rd[g]),
                .avs_write      (wr[g]),
                .avs_writedata  (wdata[g]),
                .avs_byteenable (be[g]),
                .avs_readdata   (rdata[g]),
                .avs_waitrequest(waitreq[g]),
                .coe_pfc_clk    (pclk[g]),
                .coe_pfc_reset  (preset[g]),
                .coe_pfc_cmd    (cmd[g]),
                .coe_pfc_resp   (resp[g])
            );

            always @(posedge clk) begin
                if (bank_clr) begin
                    for (int i = 0; i < 16; i++) bank[i] <= '0;
                end else if (cmd[g][36]) begin
                    bank[cmd[g][35:32]] <= cmd[g][31:0];
                end
            end

            assign resp[g] = bank[cmd[g][35:32]];
        end
    endgenerate

    typedef struct {
        int unsigned id;
        bit          rd;
        bit          strobe;
        logic [3:0]  addr;
        logic [31:0] data;
        int unsigned lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [2][16];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model helpers.
    function automatic int unsigned rw_of(input int unsigned id);
        return (id == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] merge_ref(input logic [31:0] d, input logic [3:0] b,
                                              input logic [31:0] old);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    // ---------------- monitor ----------------
    int          lat [2];
    bit          prev_stb [2];
    int          hi_cnt = 0;
    bit          end_chk = 0;
    bit          end_done = 0;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_cnt = 0;
            for (int d = 0; d < 2; d++) begin
                lat[d] = 0;
                prev_stb[d] = 0;
                chk("rst_cmd", 64'(cmd[d]), 64'h0);
                chk("rst_waitrequest", 64'(waitreq[d]), 64'h1);
                chk("rst_readdata", 64'(rdata[d]), 64'h0);
                chk("rst_pfc_reset", 64'(preset[d]), 64'h1);
                chk("pfc_clk", 64'(pclk[d]), 64'(clk));
            end
        end else begin
            hi_cnt++;
            for (int d = 0; d < 2; d++) begin
                if (hi_cnt <= 4) chk("pfc_reset_release", 64'(preset[d]), 64'(hi_cnt <= 2));
                if (preset[d] && (cmd[d][36] || !waitreq[d]))
                    chk("activity_in_pfc_reset", {62'h0, cmd[d][36], !waitreq[d]}, 64'h0);
                if (cmd[d][36]) begin
                    chk("strobe_with_ack", 64'(waitreq[d]), 64'h0);
                    chk("strobe_gap", 64'(prev_stb[d]), 64'h0);
                end
                prev_stb[d] = cmd[d][36];
                if (!waitreq[d]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 64'(d), 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_instance", 64'(d), 64'(e.id));
                        chk("strobe_present", 64'(cmd[d][36]), 64'(e.strobe));
                        if (e.strobe) chk("strobe_cmd", 64'(cmd[d]), 64'({1'b1, e.addr, e.data}));
                        if (e.rd) begin
                            chk("read_addr", 64'(cmd[d][35:32]), 64'(e.addr));
                            chk("readdata", 64'(rdata[d]), 64'(e.data));
                        end
                        chk("latency", 64'(lat[d]), 64'(e.lat));
                    end
                    lat[d] = 0;
                end else if ((rd[d] || wr[d]) && !preset[d]) begin
                    lat[d]++;
                end
            end
        end
        if (end_chk && !end_done) begin
            chk("queue_drained", 64'(exp_q.size()), 64'h0);
            end_done = 1;
        end
    end

    // ---------------- driver ----------------
    task automatic start(input int unsigned id, input bit r, input bit w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        exp_t x;
        x.id = id; x.addr = a; x.rd = r && !w;
        if (w) begin
            x.strobe = (b != 4'h0);
            x.data = merge_ref(d, b, ref_mem[id][a]);
            if (b != 4'h0) ref_mem[id][a] = x.data;
            x.lat = (b == 4'hF || b == 4'h0) ? 1 : rw_of(id) + 1;
        end else begin
            x.strobe = 0;
            x.data = ref_mem[id][a];
            x.lat = rw_of(id) + 1;
        end
        exp_q.push_back(x);
        addr[id] = a; rd[id] = r; wr[id] = w; wdata[id] = d; be[id] = b;
    endtask

    task automatic finish(input int unsigned id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                $display("FAIL timeout: instance %0d no ack after %0d cycles, expected ack", id, n);
                $fatal(1, "timeout");
            end
        end while (waitreq[id]);
        @(posedge clk); #1;
        rd[id] = 0; wr[id] = 0;
    endtask

    task automatic xfer(input int unsigned id, input bit r, input bit w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] b);
        start(id, r, w, a, d, b);
        finish(id);
    endtask

    initial begin
        rst_n = 0; bank_clr = 1;
        for (int d = 0; d < 2; d++) begin
            addr[d] = 0; rd[d] = 0; wr[d] = 0; wdata[d] = 0; be[d] = 0;
            for (int i = 0; i < 16; i++) ref_mem[d][i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        // Write presented while still in reset: must wait for the synchroniser.
        start(0, 0, 1, 4'h2, 32'hDEADBEEF, 4'hF);
        @(posedge clk); #1;
        bank_clr = 0;
        @(posedge clk); #1;
        rst_n = 1;
        finish(0);

        // Directed vectors on READ_WAIT=1.
        xfer(0, 0, 1, 4'h6, 32'h00110000, 4'hF);
        xfer(0, 0, 1, 4'hB, 32'hCAFE0001, 4'hF);
        xfer(0, 1, 0, 4'hB, 32'h0, 4'h0);
        xfer(0, 0, 1, 4'h5, 32'h11223344, 4'hF);
        xfer(0, 0, 1, 4'h5, 32'h0000AB00, 4'b0010);
        xfer(0, 1, 0, 4'h5, 32'h0, 4'h0);
        xfer(0, 0, 1, 4'h7, 32'hFFFFFFFF, 4'h0);
        xfer(0, 1, 1, 4'h9, 32'h12345678, 4'hF);
        xfer(0, 1, 0, 4'h9, 32'h0, 4'h0);
        // Back-to-back full writes.
        xfer(0, 0, 1, 4'h1, 32'hA1A1A1A1, 4'hF);
        xfer(0, 0, 1, 4'h2, 32'hB2B2B2B2, 4'hF);

        // Same partial write on READ_WAIT=3.
        xfer(1, 0, 1, 4'h5, 32'h11223344, 4'hF);
        xfer(1, 0, 1, 4'h5, 32'h0000AB00, 4'b0010);
        xfer(1, 1, 0, 4'h5, 32'h0, 4'h0);

        // Reset asserted while instance 1 sits in RD: no ack, cmd cleared.
        addr[1] = 4'hC; rd[1] = 1;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rd[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (4) @(posedge clk);
        #1;

        // Randomised traffic.
        for (int k = 0; k < 200; k++) begin
            int unsigned id;
            int unsigned kind;
            int unsigned bsel;
            logic [3:0] b;
            id = $urandom_range(0, 1);
            kind = $urandom_range(0, 3);
            bsel = $urandom_range(0, 3);
            b = (bsel == 0) ? 4'hF : (bsel == 1) ? 4'h0 : 4'($urandom);
            xfer(id, kind == 0 || kind == 3, kind != 0, 4'($urandom), $urandom, b);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        end_chk = 1;
        for (int n = 0; n < 10 && !end_done; n++) @(posedge clk);
        if (!end_done) $display("FAIL end_check: monitor did not run final check, expected it to");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
